// File: rtl/wb_target_bridge.sv
// rtl/wb_target_bridge.sv - Wishbone bridge from one upstream slave port to NUM_TGT windowed targets
// Single outstanding transfer with per-transfer timeout, decode/timeout error response and sticky error status.
module wb_target_bridge #(
   parameter int          NUM_TGT   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          WIN_BITS  = 20,
   parameter int          TIMEOUT   = 255,
   parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rstn_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   output logic [NUM_TGT-1:0]      m_cyc_o,
   output logic [NUM_TGT-1:0]      m_stb_o,
   output logic                    m_we_o,
   output logic [3:0]              m_sel_o,
   output logic [WIN_BITS-1:0]     m_adr_o,
   output logic [31:0]             m_dat_o,
   input  logic [32*NUM_TGT-1:0]   m_dat_i,
   input  logic [NUM_TGT-1:0]      m_ack_i,
   input  logic                    err_clr_i,
   output logic                    err_irq_o,
   output logic [7:0]              err_cnt_o
);

   localparam int IDX_W  = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
   localparam int TO_W   = $clog2(TIMEOUT + 1);
   localparam int HI_LSB = WIN_BITS + IDX_W;
   localparam logic [IDX_W:0]  NUM_TGT_C = (IDX_W + 1)'(NUM_TGT);
   localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                we_q, we_d;
   logic [3:0]          sel_q, sel_d;
   logic [WIN_BITS-1:0] adr_q, adr_d;
   logic [31:0]         dat_q, dat_d;
   logic [TO_W-1:0]     timer_q, timer_d;
   logic [31:0]         rdat_q, rdat_d;
   logic                err_irq_q, err_irq_d;
   logic [7:0]          err_cnt_q, err_cnt_d;

   logic [IDX_W-1:0]    req_idx;
   logic                req_hit;
   logic                ack_sel;
   logic [31:0]         rdat_sel;
   logic                err_set;

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         timer_q   <= '0;
         rdat_q    <= '0;
         err_irq_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         timer_q   <= timer_d;
         rdat_q    <= rdat_d;
         err_irq_q <= err_irq_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      we_d      = we_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      timer_d   = timer_q;
      rdat_d    = rdat_q;
      err_irq_d = err_irq_q;
      err_cnt_d = err_cnt_q;
      err_set   = 1'b0;
      ack_sel   = 1'b0;
      rdat_sel  = '0;

      req_idx = wbs_adr_i[HI_LSB-1:WIN_BITS];
      req_hit = (wbs_adr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]) && ({1'b0, req_idx} < NUM_TGT_C);

      // Only the selected target's ack/data matter; strays from other targets are ignored.
      for (int k = 0; k < NUM_TGT; k++) begin
         if (idx_q == IDX_W'(k)) begin
            ack_sel  = m_ack_i[k];
            rdat_sel = m_dat_i[32*k +: 32];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               we_d    = wbs_we_i;
               sel_d   = wbs_sel_i;
               adr_d   = wbs_adr_i[WIN_BITS-1:0];
               dat_d   = wbs_dat_i;
               timer_d = '0;
               if (req_hit) begin
                  idx_d   = req_idx;
                  state_d = S_REQ;
               end else begin
                  rdat_d  = ERR_DATA;
                  err_set = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_REQ: begin
            if (!wbs_cyc_i) begin
               state_d = S_IDLE;
            end else if (ack_sel) begin
               rdat_d  = we_q ? '0 : rdat_sel;
               state_d = S_RESP;
            end else if (timer_q == TO_MAX) begin
               rdat_d  = ERR_DATA;
               err_set = 1'b1;
               state_d = S_RESP;
            end else begin
               timer_d = timer_q + TO_W'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A new error takes priority over a simultaneous clear.
      if (err_set) begin
         err_irq_d = 1'b1;
         if (err_clr_i)               err_cnt_d = 8'd1;
         else if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else if (err_clr_i) begin
         err_irq_d = 1'b0;
         err_cnt_d = '0;
      end
   end

   always_comb begin
      m_cyc_o = '0;
      for (int k = 0; k < NUM_TGT; k++) begin
         m_cyc_o[k] = (state_q == S_REQ) && (idx_q == IDX_W'(k));
      end
   end

   assign m_stb_o   = m_cyc_o;
   assign m_we_o    = we_q;
   assign m_sel_o   = sel_q;
   assign m_adr_o   = adr_q;
   assign m_dat_o   = dat_q;
   assign wbs_ack_o = (state_q == S_RESP);
   assign wbs_dat_o = (state_q == S_RESP) ? rdat_q : '0;
   assign err_irq_o = err_irq_q;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_target_bridge.sv
// tb/tb_wb_target_bridge.sv - directed self-checking bench for wb_target_bridge
module tb_wb_target_bridge;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]   sel = '0;
   logic [31:0]  adr = '0, wdat = '0;
   logic         ack;
   logic [31:0]  rdat;
   logic [3:0]   m_cyc, m_stb;
   logic         m_we;
   logic [3:0]   m_sel;
   logic [19:0]  m_adr;
   logic [31:0]  m_dat;
   logic [127:0] m_dat_i = '0;
   logic [3:0]   m_ack = '0;
   logic         err_clr = 1'b0;
   logic         err_irq;
   logic [7:0]   err_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_target_bridge dut (
      .wb_clk_i(clk), .wb_rstn_i(rstn),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
      .m_adr_o(m_adr), .m_dat_o(m_dat), .m_dat_i(m_dat_i), .m_ack_i(m_ack),
      .err_clr_i(err_clr), .err_irq_o(err_irq), .err_cnt_o(err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
      adr = a; we = w; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
   endtask

   task automatic idle_bus();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   initial begin
      tick(); tick();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_mstb", 32'(m_stb), 32'd0);
      chk("rst_errcnt", 32'(err_cnt), 32'd0);
      rstn = 1'b1;

      // 1: read target 2, stray ack from target 1, real ack in 3rd REQ cycle
      tick(); req(32'h3020_0010, 1'b0, 4'hF, 32'h0);
      tick();
      chk("t1_mstb", 32'(m_stb), 32'h4);
      chk("t1_mcyc", 32'(m_cyc), 32'h4);
      chk("t1_madr", 32'(m_adr), 32'h00010);
      m_ack = 4'b0010; m_dat_i[32 +: 32] = 32'h1111_1111;
      tick();
      chk("t1_stray_ack", 32'(ack), 32'd0);
      chk("t1_stray_mstb", 32'(m_stb), 32'h4);
      m_ack = 4'b0000;
      tick();
      m_ack = 4'b0100; m_dat_i[64 +: 32] = 32'h1234_5678;
      tick();
      m_ack = 4'b0000;
      chk("t1_ack", 32'(ack), 32'd1);
      chk("t1_dat", rdat, 32'h1234_5678);
      chk("t1_mstb_drop", 32'(m_stb), 32'd0);
      chk("t1_irq", 32'(err_irq), 32'd0);
      tick(); idle_bus();
      chk("t1_ack_pulse", 32'(ack), 32'd0);
      chk("t1_dat_idle", rdat, 32'd0);

      // 2: write target 0, ack in first REQ cycle; write data returns 0
      tick(); req(32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_0001);
      tick();
      chk("t2_mstb", 32'(m_stb), 32'h1);
      chk("t2_mdat", m_dat, 32'hA5A5_0001);
      chk("t2_msel", 32'(m_sel), 32'h3);
      chk("t2_mwe", 32'(m_we), 32'd1);
      m_ack = 4'b0001; m_dat_i[0 +: 32] = 32'hFFFF_FFFF;
      tick();
      m_ack = 4'b0000;
      chk("t2_ack", 32'(ack), 32'd1);
      chk("t2_dat", rdat, 32'd0);
      tick(); idle_bus();
      chk("t2_single_ack", 32'(ack), 32'd0);

      // 3: decode miss
      tick(); req(32'h4000_0000, 1'b0, 4'hF, 32'h0);
      tick();
      chk("t3_ack", 32'(ack), 32'd1);
      chk("t3_dat", rdat, 32'hDEAD_BEEF);
      chk("t3_mstb", 32'(m_stb), 32'd0);
      chk("t3_irq", 32'(err_irq), 32'd1);
      chk("t3_cnt", 32'(err_cnt), 32'd1);
      tick(); idle_bus();
      chk("t3_ack_pulse", 32'(ack), 32'd0);

      // 4a: target 1 never acks -> timeout after 256 REQ cycles
      tick(); req(32'h3010_0000, 1'b0, 4'hF, 32'h0);
      tick();
      for (int i = 0; i < 255; i++) tick();
      chk("t4_mstb_last", 32'(m_stb), 32'h2);
      chk("t4_noack_yet", 32'(ack), 32'd0);
      tick();
      chk("t4_ack", 32'(ack), 32'd1);
      chk("t4_dat", rdat, 32'hDEAD_BEEF);
      chk("t4_mstb_drop", 32'(m_stb), 32'd0);
      chk("t4_cnt", 32'(err_cnt), 32'd2);
      tick(); idle_bus();

      // 4b: ack coincides with the timeout cycle -> normal data
      tick(); req(32'h3010_0000, 1'b0, 4'hF, 32'h0);
      tick();
      for (int i = 0; i < 255; i++) tick();
      m_ack = 4'b0010; m_dat_i[32 +: 32] = 32'h600D_F00D;
      tick();
      m_ack = 4'b0000;
      chk("t4b_ack", 32'(ack), 32'd1);
      chk("t4b_dat", rdat, 32'h600D_F00D);
      chk("t4b_cnt", 32'(err_cnt), 32'd2);
      tick(); idle_bus();

      // 5a: upstream abort after 2 REQ cycles
      tick(); req(32'h3030_0000, 1'b0, 4'hF, 32'h0);
      tick();
      tick();
      idle_bus();
      chk("t5_mstb_held", 32'(m_stb), 32'h8);
      tick();
      chk("t5_abort_mcyc", 32'(m_cyc), 32'd0);
      chk("t5_abort_ack", 32'(ack), 32'd0);
      tick();
      chk("t5_abort_ack2", 32'(ack), 32'd0);
      chk("t5_abort_cnt", 32'(err_cnt), 32'd2);

      // 5b: asynchronous reset mid-REQ
      tick(); req(32'h3030_0000, 1'b0, 4'hF, 32'h0);
      tick();
      chk("t5_rst_pre", 32'(m_cyc), 32'h8);
      #2 rstn = 1'b0;
      #1;
      chk("t5_rst_mcyc", 32'(m_cyc), 32'd0);
      chk("t5_rst_irq", 32'(err_irq), 32'd0);
      chk("t5_rst_cnt", 32'(err_cnt), 32'd0);
      idle_bus();
      #2 rstn = 1'b1;
      tick(); req(32'h3030_0008, 1'b0, 4'hF, 32'h0);
      tick();
      chk("t5_post_mstb", 32'(m_stb), 32'h8);
      m_ack = 4'b1000; m_dat_i[96 +: 32] = 32'hCAFE_0003;
      tick();
      m_ack = 4'b0000;
      chk("t5_post_ack", 32'(ack), 32'd1);
      chk("t5_post_dat", rdat, 32'hCAFE_0003);
      tick(); idle_bus();

      // 6: 255 misses, then one more saturates; then clear; then error vs clear
      tick(); req(32'h4000_0000, 1'b0, 4'hF, 32'h0);
      for (int i = 0; i < 255; i++) begin tick(); tick(); end
      chk("t6_cnt255", 32'(err_cnt), 32'd255);
      tick();
      chk("t6_ack256", 32'(ack), 32'd1);
      chk("t6_sat", 32'(err_cnt), 32'd255);
      tick(); idle_bus();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t6_clr_irq", 32'(err_irq), 32'd0);
      chk("t6_clr_cnt", 32'(err_cnt), 32'd0);
      req(32'h4000_0000, 1'b0, 4'hF, 32'h0);
      tick();
      chk("t6_one", 32'(err_cnt), 32'd1);
      tick(); idle_bus();
      tick(); req(32'h4000_0000, 1'b0, 4'hF, 32'h0); err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("t6_err_wins_irq", 32'(err_irq), 32'd1);
      chk("t6_err_wins_cnt", 32'(err_cnt), 32'd1);
      tick(); idle_bus();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
